regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Writer side of the pipeline register file's two write ports. Accepts results
//  from two producers: source A (ALU) and source B (load unit). Each producer has
//  a valid/ready handshake. Results are buffered in per-source FIFOs.
//  Each cycle the block drives registered reg_wr1_* (from A) and reg_wr2_* (from B)
//  straight into the register file, keeping write order for colliding destinations.
// PARAMETERS
//  DEPTH  4   entries per source FIFO; power of two, >=2
//  AW     6   register address width (64 registers)
//  DW     16  register data width
// PORTS
//  clock           in   1    rising-edge clock
//  reset           in   1    asynchronous, active-low reset
//  flush           in   1    synchronous discard of all queued/pending writes
//  a_valid         in   1    ALU result valid
//  a_ready         out  1    ALU FIFO can accept (= !a_full)
//  a_dest          in   AW   ALU destination register
//  a_data          in   DW   ALU result
//  b_valid         in   1    load result valid
//  b_ready         out  1    load FIFO can accept (= !b_full)
//  b_dest          in   AW   load destination register
//  b_data          in   DW   load result
//  reg_wr1         out  AW   write port 1 address (ALU path)
//  reg_wr1_data    out  DW   write port 1 data
//  reg_wr1_enable  out  1    write port 1 enable
//  reg_wr2         out  AW   write port 2 address (load path)
//  reg_wr2_data    out  DW   write port 2 data
//  reg_wr2_enable  out  1    write port 2 enable
//  pend_query      in   AW   register to test for a pending write
//  pend_hit        out  1    query register has a queued or issuing write
// BEHAVIOUR
//  - Reset (reset=0, async): both FIFOs empty, all reg_wr* outputs 0, pend_hit 0.
//    a_ready and b_ready are 1 after release.
//  - Push: on a rising edge with x_valid & x_ready, {x_dest,x_data} enters FIFO x.
//    If x_valid is high while x_ready is low, nothing is pushed; the producer holds.
//  - Issue: output registers load from the FIFO heads on each edge. reg_wrN_enable
//    is high for exactly one cycle per entry.
//  - Latency: entry pushed at edge k -> enable high after edge k+1 -> regfile commit
//    at edge k+2. A full, continuous stream sustains 1 write/cycle/port.
//  - Simultaneous push+pop on one FIFO: allowed, count unchanged. Push while full:
//    impossible (ready low). No pop is issued when a FIFO is empty.
//  - Collision: if both heads hold the same dest in one cycle, only A issues. B issues
//    on the next cycle, so B's value is the final one. That cycle reg_wr2_enable=0.
//  - Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. full = (count==DEPTH).
//  - flush=1 at an edge: both FIFOs are emptied and both enables are 0 next cycle.
//    Same-edge pushes are dropped; flush has priority over push and pop.
//  - Reset asserted mid-stream: everything is discarded immediately; no partial writes.
// CONFIGURATION
//  WB_PENDING_EN defined: pend_hit = 1 if any valid FIFO entry or asserted output
//    stage targets pend_query. This is combinational from state and pend_query,
//    and is used for decode hazard stalls.
//  WB_PENDING_EN undefined: the pend_query and pend_hit ports remain, but pend_hit
//    is tied to 0 and no compare logic is built.
// TESTING
//  1. Reset, then one A push dest=5 data=16'h1234 -> after edge k+1:
//     reg_wr1=5, data=1234, enable=1 for exactly 1 cycle.
//  2. Push 4 A entries with the sink idle-free and a_valid held -> a_ready drops
//     only when the FIFO is full. Order is preserved and 4 writes issue back-to-back.
//  3. A dest=9 data=AAAA and B dest=9 data=BBBB reach the heads together:
//     -> cycle n: wr1 enable=1 and wr2 enable=0; cycle n+1: wr2 enable=1.
//     The register file ends holding BBBB.
//  4. Fill B with 3 entries, then flush -> both enables are 0 next cycle,
//     b_ready=1, and no further writes occur.
//  5. WB_PENDING_EN: queue A dest=12, set pend_query=12 -> pend_hit=1 until the
//     write cycle ends, then 0. With the macro off, pend_hit stays 0.
//  6. Assert reset with 2 entries queued in each FIFO -> all outputs are 0
//     immediately. After release, FIFOs are empty and no stale writes appear.

Source files
------------

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - dual-port register file writeback queue
//
// Purpose:
//   Buffers results from the ALU (source A) and the load unit (source B) in
//   per-source FIFOs and drives them into the register file's two write
//   ports, one registered write per port per cycle. When both FIFO heads
//   target the same register, A is written first and B one cycle later, so
//   B's value is the one that survives.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   flush                        synchronous discard of all queued/pending writes
//   a_valid/a_ready/a_dest/a_data  ALU result handshake and payload
//   b_valid/b_ready/b_dest/b_data  load result handshake and payload
//   reg_wr1, reg_wr1_data, reg_wr1_enable   write port 1 (ALU path)
//   reg_wr2, reg_wr2_data, reg_wr2_enable   write port 2 (load path)
//   pend_query, pend_hit         pending-write probe for decode hazard stalls
//
// Configuration:
//   WB_PENDING_EN  when defined, pend_hit reports whether any queued entry or
//                  asserted output stage targets pend_query; otherwise pend_hit
//                  is tied to 0 and no compare logic is built.

module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_dest,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_dest,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] reg_wr1,
  output logic [DW-1:0] reg_wr1_data,
  output logic          reg_wr1_enable,
  output logic [AW-1:0] reg_wr2,
  output logic [DW-1:0] reg_wr2_data,
  output logic          reg_wr2_enable,
  input  logic [AW-1:0] pend_query,
  output logic          pend_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage; only entries inside [rd_ptr, rd_ptr+count) are meaningful
  logic [AW-1:0] a_dest_q [DEPTH];
  logic [DW-1:0] a_data_q [DEPTH];
  logic [AW-1:0] b_dest_q [DEPTH];
  logic [DW-1:0] b_data_q [DEPTH];

  logic [PW-1:0] a_rd_ptr, a_wr_ptr, b_rd_ptr, b_wr_ptr;
  logic [CW-1:0] a_count, b_count;

  logic a_push, b_push, a_pop, b_pop;
  logic a_head_valid, b_head_valid, collide;

  assign a_ready = (a_count != CW'(DEPTH));
  assign b_ready = (b_count != CW'(DEPTH));

  assign a_push = a_valid & a_ready;
  assign b_push = b_valid & b_ready;

  assign a_head_valid = (a_count != '0);
  assign b_head_valid = (b_count != '0);

  // Same destination at both heads: A goes first, B waits one cycle so that
  // the later-arriving load result is the final register value.
  assign collide = a_head_valid & b_head_valid &
                   (a_dest_q[a_rd_ptr] == b_dest_q[b_rd_ptr]);

  assign a_pop = a_head_valid;
  assign b_pop = b_head_valid & ~collide;

  // Payload storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clock) begin
    if (a_push && !flush) begin
      a_dest_q[a_wr_ptr] <= a_dest;
      a_data_q[a_wr_ptr] <= a_data;
    end
    if (b_push && !flush) begin
      b_dest_q[b_wr_ptr] <= b_dest;
      b_data_q[b_wr_ptr] <= b_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_rd_ptr <= '0;
      a_wr_ptr <= '0;
      a_count  <= '0;
      b_rd_ptr <= '0;
      b_wr_ptr <= '0;
      b_count  <= '0;
    end else if (flush) begin
      a_rd_ptr <= '0;
      a_wr_ptr <= '0;
      a_count  <= '0;
      b_rd_ptr <= '0;
      b_wr_ptr <= '0;
      b_count  <= '0;
    end else begin
      if (a_push) a_wr_ptr <= a_wr_ptr + 1'b1;
      if (a_pop)  a_rd_ptr <= a_rd_ptr + 1'b1;
      a_count <= a_count + CW'(a_push) - CW'(a_pop);
      if (b_push) b_wr_ptr <= b_wr_ptr + 1'b1;
      if (b_pop)  b_rd_ptr <= b_rd_ptr + 1'b1;
      b_count <= b_count + CW'(b_push) - CW'(b_pop);
    end
  end

  // Registered write ports; address/data only move when an entry issues
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_wr1        <= '0;
      reg_wr1_data   <= '0;
      reg_wr1_enable <= 1'b0;
      reg_wr2        <= '0;
      reg_wr2_data   <= '0;
      reg_wr2_enable <= 1'b0;
    end else if (flush) begin
      reg_wr1_enable <= 1'b0;
      reg_wr2_enable <= 1'b0;
    end else begin
      reg_wr1_enable <= a_pop;
      reg_wr2_enable <= b_pop;
      if (a_pop) begin
        reg_wr1      <= a_dest_q[a_rd_ptr];
        reg_wr1_data <= a_data_q[a_rd_ptr];
      end
      if (b_pop) begin
        reg_wr2      <= b_dest_q[b_rd_ptr];
        reg_wr2_data <= b_data_q[b_rd_ptr];
      end
    end
  end

`ifdef WB_PENDING_EN
  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] a_off;
    logic [PW-1:0] b_off;
    pend_hit = 1'b0;
    a_off    = '0;
    b_off    = '0;
    if (reg_wr1_enable && (reg_wr1 == pend_query)) pend_hit = 1'b1;
    if (reg_wr2_enable && (reg_wr2 == pend_query)) pend_hit = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a_off = PW'(i) - a_rd_ptr;
      b_off = PW'(i) - b_rd_ptr;
      if (({1'b0, a_off} < a_count) && (a_dest_q[i] == pend_query)) pend_hit = 1'b1;
      if (({1'b0, b_off} < b_count) && (b_dest_q[i] == pend_query)) pend_hit = 1'b1;
    end
  end
`else
  logic unused_pend_query;
  assign unused_pend_query = ^pend_query;
  assign pend_hit = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback

module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [5:0]  a_dest = '0, b_dest = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic [5:0]  reg_wr1, reg_wr2;
  logic [15:0] reg_wr1_data, reg_wr2_data;
  logic        reg_wr1_enable, reg_wr2_enable;
  logic [5:0]  pend_query = '0;
  logic        pend_hit;

  regfile_writeback #(.DEPTH(DEPTH), .AW(6), .DW(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .reg_wr1(reg_wr1), .reg_wr1_data(reg_wr1_data), .reg_wr1_enable(reg_wr1_enable),
    .reg_wr2(reg_wr2), .reg_wr2_data(reg_wr2_data), .reg_wr2_enable(reg_wr2_enable),
    .pend_query(pend_query), .pend_hit(pend_hit)
  );

  always #5 clock = ~clock;

  // Register file sink fed by the DUT's write ports
  logic [15:0] rf [64];
  always @(posedge clock) begin
    if (reg_wr1_enable) rf[reg_wr1] <= reg_wr1_data;
    if (reg_wr2_enable) rf[reg_wr2] <= reg_wr2_data;
  end

  // Reference model: two ordered queues plus the expected write-port contents
  typedef struct {
    logic [5:0]  dest;
    logic [15:0] data;
  } ent_t;
  ent_t qa[$];
  ent_t qb[$];
  logic [5:0]  e1, e2;
  logic [15:0] e1d, e2d;
  bit          e1e, e2e;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pend_model(input logic [5:0] q);
`ifdef WB_PENDING_EN
    foreach (qa[i]) if (qa[i].dest == q) return 1'b1;
    foreach (qb[i]) if (qb[i].dest == q) return 1'b1;
    if (e1e && e1 == q) return 1'b1;
    if (e2e && e2 == q) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs, check readiness, advance model, check outputs
  task automatic step(input bit av, input logic [5:0] ad, input logic [15:0] adt,
                      input bit bv, input logic [5:0] bd, input logic [15:0] bdt,
                      input bit fl, input logic [5:0] pq);
    bit ar, br, col;
    ent_t ea, eb;
    a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt;
    flush = fl; pend_query = pq;
    #1;
    ar = (qa.size() < DEPTH);
    br = (qb.size() < DEPTH);
    check("a_ready", a_ready, ar);
    check("b_ready", b_ready, br);
    if (fl) begin
      qa.delete();
      qb.delete();
      e1e = 0;
      e2e = 0;
    end else begin
      col = (qa.size() > 0) && (qb.size() > 0) && (qa[0].dest == qb[0].dest);
      e1e = 0;
      e2e = 0;
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        e1 = ea.dest; e1d = ea.data; e1e = 1;
      end
      if (qb.size() > 0 && !col) begin
        eb = qb.pop_front();
        e2 = eb.dest; e2d = eb.data; e2e = 1;
      end
      if (av && ar) qa.push_back('{ad, adt});
      if (bv && br) qb.push_back('{bd, bdt});
    end
    @(posedge clock);
    #1;
    check("wr1_enable", reg_wr1_enable, e1e);
    check("wr2_enable", reg_wr2_enable, e2e);
    if (e1e) begin
      check("wr1_addr", reg_wr1, e1);
      check("wr1_data", reg_wr1_data, e1d);
    end
    if (e2e) begin
      check("wr2_addr", reg_wr2, e2);
      check("wr2_data", reg_wr2_data, e2d);
    end
    check("pend_hit", pend_hit, pend_model(pq));
  endtask

  task automatic idle(input int n, input logic [5:0] pq);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, pq);
  endtask

  initial begin
    e1 = 0; e2 = 0; e1d = 0; e2d = 0; e1e = 0; e2e = 0;

    // Reset state
    @(posedge clock);
    #1;
    check("rst_wr1_enable", reg_wr1_enable, 0);
    check("rst_wr2_enable", reg_wr2_enable, 0);
    check("rst_wr1_addr", reg_wr1, 0);
    check("rst_wr2_data", reg_wr2_data, 0);
    check("rst_pend_hit", pend_hit, 0);
    reset = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);

    // Single A write: enable one cycle after the push edge, for one cycle
    step(1, 6'd5, 16'h1234, 0, 0, 0, 0, 6'd5);
    check("t1_no_early_enable", reg_wr1_enable, 0);
    step(0, 0, 0, 0, 0, 0, 0, 6'd5);
    check("t1_wr1_addr", reg_wr1, 6'd5);
    check("t1_wr1_data", reg_wr1_data, 16'h1234);
    check("t1_wr1_enable", reg_wr1_enable, 1);
    step(0, 0, 0, 0, 0, 0, 0, 6'd5);
    check("t1_enable_one_cycle", reg_wr1_enable, 0);

    // Back-to-back A stream, order preserved
    for (int i = 0; i < 4; i++) step(1, 6'(20 + i), 16'(16'hA000 + i), 0, 0, 0, 0, 6'd21);
    idle(2, 6'd21);

    // Collision: A and B both target r9
    step(1, 6'd9, 16'hAAAA, 1, 6'd9, 16'hBBBB, 0, 6'd9);
    step(0, 0, 0, 0, 0, 0, 0, 6'd9);
    check("t3_wr1_enable", reg_wr1_enable, 1);
    check("t3_wr2_blocked", reg_wr2_enable, 0);
    step(0, 0, 0, 0, 0, 0, 0, 6'd9);
    check("t3_wr2_enable", reg_wr2_enable, 1);
    idle(1, 6'd9);
    check("t3_rf9_final", rf[9], 16'hBBBB);

    // Back B up behind same-dest A entries until it is full
    for (int i = 0; i < 7; i++) step(1, 6'd7, 16'(i), 1, 6'd7, 16'(16'hB000 + i), 0, 6'd7);
    check("t2_b_full", b_ready, 0);
    idle(10, 6'd7);

    // Fill B with 3 entries, then flush
    for (int i = 0; i < 4; i++) step(1, 6'd3, 16'(i), (i < 3), 6'd3, 16'(16'hC000 + i), 0, 6'd3);
    step(1, 6'd3, 16'h5555, 1, 6'd3, 16'h6666, 1, 6'd3);
    check("t4_wr1_off", reg_wr1_enable, 0);
    check("t4_wr2_off", reg_wr2_enable, 0);
    check("t4_b_ready", b_ready, 1);
    idle(3, 6'd3);

    // Pending probe on r12
    step(1, 6'd12, 16'h0C0C, 0, 0, 0, 0, 6'd12);
    idle(3, 6'd12);

    // Reset asserted with traffic in flight
    step(1, 6'd1, 16'h1111, 1, 6'd1, 16'h2222, 0, 6'd1);
    step(1, 6'd1, 16'h3333, 1, 6'd1, 16'h4444, 0, 6'd1);
    a_valid = 0; b_valid = 0;
    #2 reset = 1'b0;
    #1;
    check("t6_wr1_enable", reg_wr1_enable, 0);
    check("t6_wr2_enable", reg_wr2_enable, 0);
    check("t6_wr1_addr", reg_wr1, 0);
    check("t6_wr1_data", reg_wr1_data, 0);
    check("t6_wr2_addr", reg_wr2, 0);
    check("t6_pend_hit", pend_hit, 0);
    qa.delete(); qb.delete();
    e1e = 0; e2e = 0;
    @(posedge clock);
    #1 reset = 1'b1;
    idle(4, 6'd1);

    // Randomized traffic with narrow dest range to provoke collisions
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 16'($urandom),
           ($urandom_range(0, 24) == 0), 6'($urandom_range(0, 4)));
    end
    idle(8, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
